// File: rtl/sprite_renderer_pkg.sv
// sprite_renderer_pkg
//   Shared definitions for the sprite renderer: sprite type codes, the per-type
//   width/height table, image sizes, ROM address width, background colour and
//   the return-pipeline record.
package sprite_renderer_pkg;

   typedef enum logic [1:0] {
      SprDino     = 2'b00,
      SprDinoDuck = 2'b01,
      SprCactus   = 2'b10,
      SprBird     = 2'b11
   } sprite_type_e;

   localparam int unsigned DINO_W      = 20;
   localparam int unsigned DINO_H      = 22;
   localparam int unsigned DINO_DUCK_W = 28;
   localparam int unsigned DINO_DUCK_H = 14;
   localparam int unsigned CACTUS_W    = 12;
   localparam int unsigned CACTUS_H    = 24;
   localparam int unsigned BIRD_W      = 22;
   localparam int unsigned BIRD_H      = 16;

   localparam int unsigned DINO_IMG_SIZE      = DINO_W * DINO_H;
   localparam int unsigned DINO_DUCK_IMG_SIZE = DINO_DUCK_W * DINO_DUCK_H;
   localparam int unsigned CACTUS_IMG_SIZE    = CACTUS_W * CACTUS_H;
   localparam int unsigned BIRD_IMG_SIZE      = BIRD_W * BIRD_H;

   localparam int unsigned MAX_AB_IMG_SIZE =
      (DINO_IMG_SIZE > DINO_DUCK_IMG_SIZE) ? DINO_IMG_SIZE : DINO_DUCK_IMG_SIZE;
   localparam int unsigned MAX_CD_IMG_SIZE =
      (CACTUS_IMG_SIZE > BIRD_IMG_SIZE) ? CACTUS_IMG_SIZE : BIRD_IMG_SIZE;
   localparam int unsigned MAX_IMG_SIZE =
      (MAX_AB_IMG_SIZE > MAX_CD_IMG_SIZE) ? MAX_AB_IMG_SIZE : MAX_CD_IMG_SIZE;

   localparam int unsigned SPRITE_ADDR_WIDTH = $clog2(MAX_IMG_SIZE);

   // Wide enough for the largest sprite dimension.
   localparam int unsigned SPRITE_DIM_W = 6;

   localparam logic [7:0] BG_COLOR = 8'hB6;

   // One entry of the return-side shift register.
   typedef struct packed {
      logic hit;
      logic de;
      logic hs;
      logic vs;
   } pipe_t;

   function automatic logic [SPRITE_DIM_W-1:0] obj_w(input sprite_type_e t);
      case (t)
         SprDino:     obj_w = SPRITE_DIM_W'(DINO_W);
         SprDinoDuck: obj_w = SPRITE_DIM_W'(DINO_DUCK_W);
         SprCactus:   obj_w = SPRITE_DIM_W'(CACTUS_W);
         SprBird:     obj_w = SPRITE_DIM_W'(BIRD_W);
         default:     obj_w = SPRITE_DIM_W'(DINO_W);
      endcase
   endfunction

   function automatic logic [SPRITE_DIM_W-1:0] obj_h(input sprite_type_e t);
      case (t)
         SprDino:     obj_h = SPRITE_DIM_W'(DINO_H);
         SprDinoDuck: obj_h = SPRITE_DIM_W'(DINO_DUCK_H);
         SprCactus:   obj_h = SPRITE_DIM_W'(CACTUS_H);
         SprBird:     obj_h = SPRITE_DIM_W'(BIRD_H);
         default:     obj_h = SPRITE_DIM_W'(DINO_H);
      endcase
   endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// sprite_hit_test
//   Bounds comparator for one object slot against the current beam position.
//   Ports:
//     i_en            slot enable
//     i_type          sprite type code (selects width/height)
//     i_obj_x/i_obj_y top-left corner of the object
//     i_x/i_y         beam position
//     o_hit           beam inside the object rectangle
//     o_dx/o_dy       beam offset from the top-left corner (valid when o_hit)
module sprite_hit_test
   import sprite_renderer_pkg::*;
#(
   parameter int unsigned COORD_W = 10
) (
   input  logic               i_en,
   input  logic [1:0]         i_type,
   input  logic [COORD_W-1:0] i_obj_x,
   input  logic [COORD_W-1:0] i_obj_y,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   output logic               o_hit,
   output logic [COORD_W-1:0] o_dx,
   output logic [COORD_W-1:0] o_dy
);

   // One extra bit so that ox+W past the top of the coordinate range cannot wrap.
   logic [COORD_W:0] x_ext, y_ext, ox_ext, oy_ext, x_end, y_end;

   always_comb begin
      x_ext  = {1'b0, i_x};
      y_ext  = {1'b0, i_y};
      ox_ext = {1'b0, i_obj_x};
      oy_ext = {1'b0, i_obj_y};
      x_end  = ox_ext + (COORD_W+1)'(obj_w(sprite_type_e'(i_type)));
      y_end  = oy_ext + (COORD_W+1)'(obj_h(sprite_type_e'(i_type)));
      o_hit  = i_en && (x_ext >= ox_ext) && (x_ext < x_end) &&
               (y_ext >= oy_ext) && (y_ext < y_end);
      o_dx   = i_x - i_obj_x;
      o_dy   = i_y - i_obj_y;
   end

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer
//   Turns the beam position and a per-frame latched object list into sprite ROM
//   requests, then composites the returned colour over BG_COLOR with de/hs/vs
//   delayed to match. Output lags the beam by SPRITE_LAT+2 clocks.
//   Optional build macro SPRITE_RENDERER_MIRROR_EN adds per-slot horizontal flip.
//   Ports:
//     i_clk, i_rst_n              pixel clock, async active-low reset
//     i_x, i_y, i_de, i_hs, i_vs  beam position and timing from the VGA generator
//     i_frame_start               latches i_obj_* into the shadow registers
//     i_obj_en/type/x/y           object list (packed, slot k at index k)
//     i_obj_flip                  per-slot mirror (MIRROR_EN builds only)
//     o_sel, o_addr               sprite ROM request
//     i_pixel_color               ROM data, SPRITE_LAT clocks after the request
//     o_color, o_de, o_hs, o_vs   composited pixel and aligned timing
module sprite_renderer
   import sprite_renderer_pkg::*;
#(
   parameter int unsigned NUM_OBJ    = 4,
   parameter int unsigned COORD_W    = 10,
   parameter int unsigned SPRITE_LAT = 3
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [COORD_W-1:0]           i_x,
   input  logic [COORD_W-1:0]           i_y,
   input  logic                         i_de,
   input  logic                         i_hs,
   input  logic                         i_vs,
   input  logic                         i_frame_start,
   input  logic [NUM_OBJ-1:0]           i_obj_en,
   input  logic [2*NUM_OBJ-1:0]         i_obj_type,
   input  logic [COORD_W*NUM_OBJ-1:0]   i_obj_x,
   input  logic [COORD_W*NUM_OBJ-1:0]   i_obj_y,
`ifdef SPRITE_RENDERER_MIRROR_EN
   input  logic [NUM_OBJ-1:0]           i_obj_flip,
`endif
   output logic [1:0]                   o_sel,
   output logic [SPRITE_ADDR_WIDTH-1:0] o_addr,
   input  logic [7:0]                   i_pixel_color,
   output logic [7:0]                   o_color,
   output logic                         o_de,
   output logic                         o_hs,
   output logic                         o_vs
);

   // Shadow object list
   logic [NUM_OBJ-1:0]         obj_en_q, obj_en_d;
   logic [2*NUM_OBJ-1:0]       obj_type_q, obj_type_d;
   logic [COORD_W*NUM_OBJ-1:0] obj_x_q, obj_x_d;
   logic [COORD_W*NUM_OBJ-1:0] obj_y_q, obj_y_d;
`ifdef SPRITE_RENDERER_MIRROR_EN
   logic [NUM_OBJ-1:0]         obj_flip_q, obj_flip_d;
`endif

   always_comb begin
      obj_en_d   = obj_en_q;
      obj_type_d = obj_type_q;
      obj_x_d    = obj_x_q;
      obj_y_d    = obj_y_q;
`ifdef SPRITE_RENDERER_MIRROR_EN
      obj_flip_d = obj_flip_q;
`endif
      if (i_frame_start) begin
         obj_en_d   = i_obj_en;
         obj_type_d = i_obj_type;
         obj_x_d    = i_obj_x;
         obj_y_d    = i_obj_y;
`ifdef SPRITE_RENDERER_MIRROR_EN
         obj_flip_d = i_obj_flip;
`endif
      end
   end

   // Per-slot hit test on the shadow list
   logic [NUM_OBJ-1:0] slot_hit;
   logic [COORD_W-1:0] slot_dx [NUM_OBJ];
   logic [COORD_W-1:0] slot_dy [NUM_OBJ];

   for (genvar k = 0; k < NUM_OBJ; k++) begin : g_slot
      sprite_hit_test #(
         .COORD_W (COORD_W)
      ) u_hit_test (
         .i_en    (obj_en_q[k]),
         .i_type  (obj_type_q[2*k +: 2]),
         .i_obj_x (obj_x_q[COORD_W*k +: COORD_W]),
         .i_obj_y (obj_y_q[COORD_W*k +: COORD_W]),
         .i_x     (i_x),
         .i_y     (i_y),
         .o_hit   (slot_hit[k]),
         .o_dx    (slot_dx[k]),
         .o_dy    (slot_dy[k])
      );
   end

   // Priority encoder: the lowest-index hitting slot owns the pixel outright,
   // even where its texel is transparent.
   logic                         win_hit;
   logic [1:0]                   win_type;
   logic [COORD_W-1:0]           win_dx;
   logic [COORD_W-1:0]           win_dy;
   logic [SPRITE_DIM_W-1:0]      win_w;
   logic [COORD_W-1:0]           dx_eff;
   logic [SPRITE_ADDR_WIDTH-1:0] addr_calc;
`ifdef SPRITE_RENDERER_MIRROR_EN
   logic                         win_flip;
`endif

   always_comb begin
      win_hit  = 1'b0;
      win_type = 2'b00;
      win_dx   = '0;
      win_dy   = '0;
`ifdef SPRITE_RENDERER_MIRROR_EN
      win_flip = 1'b0;
`endif
      for (int k = 0; k < int'(NUM_OBJ); k++) begin
         if (slot_hit[k] && !win_hit) begin
            win_hit  = 1'b1;
            win_type = obj_type_q[2*k +: 2];
            win_dx   = slot_dx[k];
            win_dy   = slot_dy[k];
`ifdef SPRITE_RENDERER_MIRROR_EN
            win_flip = obj_flip_q[k];
`endif
         end
      end

      win_w  = obj_w(sprite_type_e'(win_type));
      dx_eff = win_dx;
`ifdef SPRITE_RENDERER_MIRROR_EN
      if (win_flip) begin
         dx_eff = COORD_W'(win_w) - COORD_W'(1) - win_dx;
      end
`endif
      // dy < H and dx < W on a hit, so the row-major address fits the ROM range.
      addr_calc = SPRITE_ADDR_WIDTH'(win_dy) * SPRITE_ADDR_WIDTH'(win_w) +
                  SPRITE_ADDR_WIDTH'(dx_eff);
   end

   // Request stage; sel/addr hold on a miss to avoid toggling the ROM.
   logic [1:0]                   sel_q, sel_d;
   logic [SPRITE_ADDR_WIDTH-1:0] addr_q, addr_d;

   always_comb begin
      sel_d  = sel_q;
      addr_d = addr_q;
      if (win_hit) begin
         sel_d  = win_type;
         addr_d = addr_calc;
      end
   end

   // Return shift register: entry 0 is loaded alongside the request, so the
   // tail lines up with i_pixel_color SPRITE_LAT clocks later.
   pipe_t [SPRITE_LAT:0] pipe_q, pipe_d;
   pipe_t                pipe_head;
   pipe_t                pipe_tail;

   always_comb begin
      pipe_head.hit = win_hit;
      pipe_head.de  = i_de;
      pipe_head.hs  = i_hs;
      pipe_head.vs  = i_vs;
      pipe_d        = {pipe_q[SPRITE_LAT-1:0], pipe_head};
      pipe_tail     = pipe_q[SPRITE_LAT];
   end

   // Output stage
   logic [7:0] color_q, color_d;
   logic       de_q, de_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;

   always_comb begin
      color_d = 8'h00;
      if (pipe_tail.de) begin
         color_d = pipe_tail.hit ? i_pixel_color : BG_COLOR;
      end
      de_d = pipe_tail.de;
      hs_d = pipe_tail.hs;
      vs_d = pipe_tail.vs;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         obj_en_q   <= '0;
         obj_type_q <= '0;
         obj_x_q    <= '0;
         obj_y_q    <= '0;
`ifdef SPRITE_RENDERER_MIRROR_EN
         obj_flip_q <= '0;
`endif
         sel_q      <= '0;
         addr_q     <= '0;
         pipe_q     <= '0;
         color_q    <= '0;
         de_q       <= 1'b0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
      end else begin
         obj_en_q   <= obj_en_d;
         obj_type_q <= obj_type_d;
         obj_x_q    <= obj_x_d;
         obj_y_q    <= obj_y_d;
`ifdef SPRITE_RENDERER_MIRROR_EN
         obj_flip_q <= obj_flip_d;
`endif
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         pipe_q     <= pipe_d;
         color_q    <= color_d;
         de_q       <= de_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
      end
   end

   assign o_sel   = sel_q;
   assign o_addr  = addr_q;
   assign o_color = color_q;
   assign o_de    = de_q;
   assign o_hs    = hs_q;
   assign o_vs    = vs_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer
//   Directed, table-driven bench for sprite_renderer plus hand sequences for
//   reset, priority, shadow latching, sync latency and (MIRROR_EN) flipping.
module tb_sprite_renderer;
   import sprite_renderer_pkg::*;

   localparam int unsigned NUM_OBJ    = 4;
   localparam int unsigned COORD_W    = 10;
   localparam int unsigned SPRITE_LAT = 3;
   localparam int unsigned AW         = SPRITE_ADDR_WIDTH;
   localparam int unsigned IDLE       = 1023;

   logic                       i_clk;
   logic                       i_rst_n;
   logic [COORD_W-1:0]         i_x, i_y;
   logic                       i_de, i_hs, i_vs;
   logic                       i_frame_start;
   logic [NUM_OBJ-1:0]         i_obj_en;
   logic [2*NUM_OBJ-1:0]       i_obj_type;
   logic [COORD_W*NUM_OBJ-1:0] i_obj_x, i_obj_y;
`ifdef SPRITE_RENDERER_MIRROR_EN
   logic [NUM_OBJ-1:0]         i_obj_flip;
`endif
   logic [1:0]                 o_sel;
   logic [AW-1:0]              o_addr;
   logic [7:0]                 i_pixel_color;
   logic [7:0]                 o_color;
   logic                       o_de, o_hs, o_vs;

   sprite_renderer #(
      .NUM_OBJ    (NUM_OBJ),
      .COORD_W    (COORD_W),
      .SPRITE_LAT (SPRITE_LAT)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_x           (i_x),
      .i_y           (i_y),
      .i_de          (i_de),
      .i_hs          (i_hs),
      .i_vs          (i_vs),
      .i_frame_start (i_frame_start),
      .i_obj_en      (i_obj_en),
      .i_obj_type    (i_obj_type),
      .i_obj_x       (i_obj_x),
      .i_obj_y       (i_obj_y),
`ifdef SPRITE_RENDERER_MIRROR_EN
      .i_obj_flip    (i_obj_flip),
`endif
      .o_sel         (o_sel),
      .o_addr        (o_addr),
      .i_pixel_color (i_pixel_color),
      .o_color       (o_color),
      .o_de          (o_de),
      .o_hs          (o_hs),
      .o_vs          (o_vs)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               de;
      logic               hs;
      logic               vs;
      logic               fs;
      logic [7:0]         pix;
      logic [1:0]         exp_sel;
      logic [AW-1:0]      exp_addr;
      logic [7:0]         exp_color;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int x, input int y, input logic de, input logic hs,
                               input logic vs, input logic fs, input logic [7:0] pix,
                               input logic [1:0] sel, input int addr,
                               input logic [7:0] color);
      vec_t v;
      v.x = COORD_W'(x);
      v.y = COORD_W'(y);
      v.de = de;
      v.hs = hs;
      v.vs = vs;
      v.fs = fs;
      v.pix = pix;
      v.exp_sel = sel;
      v.exp_addr = AW'(addr);
      v.exp_color = color;
      return v;
   endfunction

   task automatic drive_idle();
      i_x = COORD_W'(IDLE);
      i_y = COORD_W'(IDLE);
      i_de = 1'b0;
      i_hs = 1'b0;
      i_vs = 1'b0;
      i_frame_start = 1'b0;
      i_pixel_color = 8'h00;
   endtask

   // Beam at cycle n; request checked in n+1; ROM data driven in n+4; output checked in n+5.
   task automatic run_vec(input string tag, input vec_t v);
      i_x = v.x;
      i_y = v.y;
      i_de = v.de;
      i_hs = v.hs;
      i_vs = v.vs;
      i_frame_start = v.fs;
      @(negedge i_clk);
      drive_idle();
      check({tag, " sel"}, 32'(o_sel), 32'(v.exp_sel));
      check({tag, " addr"}, 32'(o_addr), 32'(v.exp_addr));
      @(negedge i_clk);
      @(negedge i_clk);
      @(negedge i_clk);
      i_pixel_color = v.pix;
      @(negedge i_clk);
      i_pixel_color = 8'h00;
      check({tag, " color"}, 32'(o_color), 32'(v.exp_color));
      check({tag, " sync"}, 32'({o_de, o_hs, o_vs}), 32'({v.de, v.hs, v.vs}));
   endtask

   task automatic set_obj(input int s, input logic en, input logic [1:0] t, input int x,
                          input int y);
      i_obj_en[s] = en;
      i_obj_type[2*s +: 2] = t;
      i_obj_x[COORD_W*s +: COORD_W] = COORD_W'(x);
      i_obj_y[COORD_W*s +: COORD_W] = COORD_W'(y);
   endtask

   task automatic pulse_frame();
      i_frame_start = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " sel"}, 32'(o_sel), 32'd0);
      check({tag, " addr"}, 32'(o_addr), 32'd0);
      check({tag, " color"}, 32'(o_color), 32'd0);
      check({tag, " sync"}, 32'({o_de, o_hs, o_vs}), 32'd0);
   endtask

   vec_t tbl [12];
   logic [2:0] hist [25];

   initial begin
      i_rst_n = 1'b0;
      drive_idle();
      i_obj_en = '0;
      i_obj_type = '0;
      i_obj_x = '0;
      i_obj_y = '0;
`ifdef SPRITE_RENDERER_MIRROR_EN
      i_obj_flip = '0;
`endif

      // Config A: dino, cactus past the coordinate top, bird at origin, duck off-screen edge.
      tbl[0]  = mk(100, 200, 1, 0, 0, 0, 8'h11, 2'b00,   0, 8'h11);
      tbl[1]  = mk(119, 221, 1, 0, 0, 0, 8'h22, 2'b00, 439, 8'h22);
      tbl[2]  = mk(120, 200, 1, 0, 0, 0, 8'hFF, 2'b00, 439, BG_COLOR);
      tbl[3]  = mk(100, 222, 1, 0, 0, 0, 8'hFF, 2'b00, 439, BG_COLOR);
      tbl[4]  = mk( 99, 200, 1, 0, 0, 0, 8'hFF, 2'b00, 439, BG_COLOR);
      tbl[5]  = mk(1023, 55, 1, 0, 0, 0, 8'h33, 2'b10,  63, 8'h33);
      tbl[6]  = mk(  0,   0, 1, 0, 0, 0, 8'h44, 2'b11,   0, 8'h44);
      tbl[7]  = mk( 21,  15, 1, 0, 0, 0, 8'h55, 2'b11, 351, 8'h55);
      tbl[8]  = mk( 22,  15, 1, 0, 0, 0, 8'hFF, 2'b11, 351, BG_COLOR);
      tbl[9]  = mk(639, 313, 1, 0, 0, 0, 8'h66, 2'b01, 373, 8'h66);
      tbl[10] = mk(110, 210, 0, 1, 0, 0, 8'h99, 2'b00, 210, 8'h00);
      tbl[11] = mk(105, 205, 1, 0, 1, 0, 8'h77, 2'b00, 105, 8'h77);

      @(negedge i_clk);
      check_all_zero("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      set_obj(0, 1'b1, 2'b00, 100, 200);
      set_obj(1, 1'b1, 2'b10, 1020, 50);
      set_obj(2, 1'b1, 2'b11, 0, 0);
      set_obj(3, 1'b1, 2'b01, 630, 300);
      // Not yet latched: background only.
      run_vec("prelatch", mk(100, 200, 1, 0, 0, 0, 8'h11, 2'b00, 0, BG_COLOR));

      pulse_frame();
      for (int i = 0; i < 12; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i]);
      end

      // Mid-frame reset: outputs clear at once, shadow list is wiped.
      i_rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      run_vec("postrst", mk(100, 200, 1, 0, 0, 0, 8'h11, 2'b00, 0, BG_COLOR));
      pulse_frame();
      run_vec("relatch", mk(110, 201, 1, 0, 0, 0, 8'h12, 2'b00, 30, 8'h12));

      // Priority: cactus in slot0 over bird in slot2.
      set_obj(0, 1'b1, 2'b10, 300, 150);
      set_obj(1, 1'b0, 2'b00, 0, 0);
      set_obj(2, 1'b1, 2'b11, 300, 150);
      set_obj(3, 1'b0, 2'b00, 0, 0);
      pulse_frame();
      run_vec("prio0", mk(300, 150, 1, 0, 0, 0, 8'h21, 2'b10, 0, 8'h21));
      run_vec("prio_fall", mk(315, 150, 1, 0, 0, 0, 8'h23, 2'b11, 15, 8'h23));
      set_obj(0, 1'b0, 2'b10, 300, 150);
      pulse_frame();
      run_vec("prio2", mk(300, 150, 1, 0, 0, 0, 8'h24, 2'b11, 0, 8'h24));

      // Mid-frame move is ignored until the next latch.
      set_obj(2, 1'b1, 2'b11, 500, 150);
      run_vec("shadow_old", mk(300, 150, 1, 0, 0, 0, 8'h25, 2'b11, 0, 8'h25));
      run_vec("shadow_new_miss", mk(500, 150, 1, 0, 0, 0, 8'hFF, 2'b11, 0, BG_COLOR));
      // Latch coincident with a pixel: that pixel still sees the old position.
      run_vec("latch_same", mk(305, 152, 1, 0, 0, 1, 8'h26, 2'b11, 49, 8'h26));
      run_vec("latch_next", mk(510, 152, 1, 0, 0, 0, 8'h27, 2'b11, 54, 8'h27));
      run_vec("latch_oldmiss", mk(305, 152, 1, 0, 0, 0, 8'hFF, 2'b11, 54, BG_COLOR));

      // Streaming sync pattern: every output must equal the input five clocks earlier.
      for (int i = 0; i < 25; i++) begin
         logic [2:0] s;
         s = (i < 20) ? {(i[0] ^ i[2]), i[1], (i % 5 == 0)} : 3'b000;
         hist[i] = s;
         i_x = COORD_W'(IDLE);
         i_y = COORD_W'(IDLE);
         {i_de, i_hs, i_vs} = s;
         @(negedge i_clk);
         if (i >= 4) begin
            check($sformatf("stream%0d sync", i), 32'({o_de, o_hs, o_vs}), 32'(hist[i-4]));
            check($sformatf("stream%0d color", i), 32'(o_color),
                  hist[i-4][2] ? 32'(BG_COLOR) : 32'd0);
         end
      end
      drive_idle();

`ifdef SPRITE_RENDERER_MIRROR_EN
      set_obj(0, 1'b1, 2'b00, 100, 200);
      set_obj(2, 1'b0, 2'b11, 0, 0);
      i_obj_flip = 4'b0001;
      pulse_frame();
      run_vec("flip_l", mk(100, 200, 1, 0, 0, 0, 8'h31, 2'b00, 19, 8'h31));
      run_vec("flip_r", mk(119, 200, 1, 0, 0, 0, 8'h32, 2'b00, 0, 8'h32));
      run_vec("flip_mid", mk(105, 201, 1, 0, 0, 0, 8'h34, 2'b00, 34, 8'h34));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
